bicubic_phase_scheduler: RTL and testbench

- Sequences the 4×4 weight-vector × pixel-matrix multiplier stage of the bicubic upscaler.
- Accepts one 4×4 source-pixel window per handshake and holds it on the multiplier pixel inputs.
- Issues the four horizontal sub-pixel phases of the ×4 kernel as 3-bit weight codes, one phase per cycle.
- Drives the multiplier's `ena` and tracks its pipeline so that each phase's four inner products emerge with a valid/ready handshake toward the vertical stage.

---
 rtl/bicubic_phase_scheduler.sv | 136 +++++++++++++
 tb/tb_bicubic_phase_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_phase_scheduler.sv
// Phase scheduler for the 4x4 weight-vector x pixel-matrix multiplier of the bicubic upscaler.
// Optional stall counter enabled by defining BICUBIC_SCHED_PERF_EN.
module bicubic_phase_scheduler #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned PIPE_LAT      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           win_valid,
  output logic                           win_ready,
  input  logic [16*(CHANNEL_WIDTH+1)-1:0] win_data,
  output logic [16*(CHANNEL_WIDTH+1)-1:0] p_bus,
  output logic [2:0]                     w1,
  output logic [2:0]                     w2,
  output logic [2:0]                     w3,
  output logic [2:0]                     w4,
  output logic                           ena,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:0]                     out_phase,
  output logic                           out_last,
  output logic [31:0]                    stall_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                       state;
  logic [1:0]                   ph;
  logic [11:0]                  wcode;
  logic                         accept;
  logic [PIPE_LAT-1:0]          tag_v;
  logic [PIPE_LAT-1:0]          tag_l;
  logic [PIPE_LAT-1:0][1:0]     tag_p;

  // Packed {w4, w3, w2, w1} for phase k; w3/w4 mirror w2/w1.
  function automatic logic [11:0] phase_codes(input logic [1:0] k);
    logic [2:0] k3;
    k3 = {1'b0, k};
    return {3'd3 - k3, 3'd7 - k3, 3'd4 + k3, k3};
  endfunction

  // A presented but unaccepted product freezes the whole stage, multiplier included.
  assign ena       = ~(out_valid & ~out_ready);
  assign win_ready = ena & ((state == IDLE) | ((state == ISSUE) & (ph == 2'd3)));
  assign accept    = win_valid & win_ready;

  assign w1 = wcode[2:0];
  assign w2 = wcode[5:3];
  assign w3 = wcode[8:6];
  assign w4 = wcode[11:9];

  // Window/phase sequencer; weight codes are registered alongside ph.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph    <= 2'd0;
      p_bus <= '0;
      wcode <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ISSUE;
            ph    <= 2'd0;
            p_bus <= win_data;
            wcode <= phase_codes(2'd0);
          end
        end
        ISSUE: begin
          if (ph == 2'd3) begin
            if (accept) begin
              ph    <= 2'd0;
              p_bus <= win_data;
              wcode <= phase_codes(2'd0);
            end else begin
              state <= IDLE;
              ph    <= 2'd0;
              wcode <= '0;
            end
          end else begin
            ph    <= ph + 2'd1;
            wcode <= phase_codes(ph + 2'd1);
          end
        end
        default: begin
          state <= IDLE;
          ph    <= 2'd0;
          wcode <= '0;
        end
      endcase
    end
  end

  // Tag pipeline mirrors the multiplier latency so tags leave with their products.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_l <= '0;
      tag_p <= '0;
    end else if (ena) begin
      tag_v[0] <= (state == ISSUE);
      tag_p[0] <= ph;
      tag_l[0] <= (ph == 2'd3);
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  assign out_valid = tag_v[PIPE_LAT-1];
  assign out_phase = tag_p[PIPE_LAT-1];
  assign out_last  = tag_l[PIPE_LAT-1];

`ifdef BICUBIC_SCHED_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of frozen cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (!ena && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bicubic_phase_scheduler.sv
// Directed, table-driven bench for bicubic_phase_scheduler (defaults: CHANNEL_WIDTH=8, PIPE_LAT=2).
module tb_bicubic_phase_scheduler;

  localparam int unsigned PW = 9;
  localparam int unsigned BW = 16 * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          win_valid = 1'b0;
  logic          win_ready;
  logic [BW-1:0] win_data = '0;
  logic [BW-1:0] p_bus;
  logic [2:0]    w1, w2, w3, w4;
  logic          ena;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    out_phase;
  logic          out_last;
  logic [31:0]   stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bicubic_phase_scheduler #(.CHANNEL_WIDTH(8), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .p_bus(p_bus), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .ena(ena), .out_valid(out_valid), .out_ready(out_ready),
    .out_phase(out_phase), .out_last(out_last), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic wv;
    int   wsel;
    logic ordy;
    logic e_wr;
    logic e_ena;
    logic e_ov;
    int   e_oph;
    logic e_last;
    int   e_k;     // issuing phase, -1 = idle (codes zero)
    int   e_psel;  // window index expected on p_bus, 0 = cleared
  } vec_t;

  vec_t tbl[25];

  function automatic logic [BW-1:0] mkwin(input int s);
    logic [BW-1:0] r;
    r = '0;
    if (s != 0)
      for (int i = 0; i < 16; i++) r[i*PW +: PW] = 9'((s * 37 + i * 5 + 1) & 511);
    return r;
  endfunction

  function automatic vec_t mkv(input logic wv, input int wsel, input logic ordy,
                               input logic wr, input logic en, input logic ov,
                               input int oph, input logic last, input int k, input int psel);
    vec_t v;
    v.wv = wv; v.wsel = wsel; v.ordy = ordy; v.e_wr = wr; v.e_ena = en; v.e_ov = ov;
    v.e_oph = oph; v.e_last = last; v.e_k = k; v.e_psel = psel;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input int k);
    logic [2:0] e1, e2, e3, e4;
    if (k < 0) begin
      e1 = 3'd0; e2 = 3'd0; e3 = 3'd0; e4 = 3'd0;
    end else begin
      e1 = 3'(k); e2 = 3'(4 + k); e3 = 3'(7 - k); e4 = 3'(3 - k);
    end
    chk({nm, ".w"}, BW'({w4, w3, w2, w1}), BW'({e4, e3, e2, e1}));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int acc;
  logic [31:0] exp_stall;

  initial begin
    // power-on reset
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ov", BW'(out_valid), BW'(1'b0));
    chk("rst.wr", BW'(win_ready), BW'(1'b1));
    chk("rst.ena", BW'(ena), BW'(1'b1));
    chk("rst.phase", BW'({out_last, out_phase}), BW'(3'd0));
    chk("rst.pbus", p_bus, '0);
    chk("rst.stall", BW'(stall_cnt), BW'(32'd0));
    chk_w("rst", -1);
    adv();

    // single window, then backpressure with a window request at ph=3 during the stall
    tbl[0]  = mkv(1, 1, 1, 1, 1, 0, 0, 0, -1, 0);
    tbl[1]  = mkv(0, 0, 1, 0, 1, 0, 0, 0,  0, 1);
    tbl[2]  = mkv(0, 0, 1, 0, 1, 0, 0, 0,  1, 1);
    tbl[3]  = mkv(0, 0, 1, 0, 1, 1, 0, 0,  2, 1);
    tbl[4]  = mkv(0, 0, 1, 1, 1, 1, 1, 0,  3, 1);
    tbl[5]  = mkv(0, 0, 1, 1, 1, 1, 2, 0, -1, 1);
    tbl[6]  = mkv(0, 0, 1, 1, 1, 1, 3, 1, -1, 1);
    tbl[7]  = mkv(0, 0, 1, 1, 1, 0, 0, 0, -1, 1);
    tbl[8]  = mkv(1, 2, 1, 1, 1, 0, 0, 0, -1, 1);
    tbl[9]  = mkv(0, 0, 1, 0, 1, 0, 0, 0,  0, 2);
    tbl[10] = mkv(0, 0, 1, 0, 1, 0, 0, 0,  1, 2);
    tbl[11] = mkv(0, 0, 1, 0, 1, 1, 0, 0,  2, 2);
    tbl[12] = mkv(0, 0, 0, 0, 0, 1, 1, 0,  3, 2);
    tbl[13] = mkv(0, 0, 0, 0, 0, 1, 1, 0,  3, 2);
    tbl[14] = mkv(1, 3, 0, 0, 0, 1, 1, 0,  3, 2);
    tbl[15] = mkv(1, 3, 0, 0, 0, 1, 1, 0,  3, 2);
    tbl[16] = mkv(1, 3, 0, 0, 0, 1, 1, 0,  3, 2);
    tbl[17] = mkv(1, 3, 1, 1, 1, 1, 1, 0,  3, 2);
    tbl[18] = mkv(0, 0, 1, 0, 1, 1, 2, 0,  0, 3);
    tbl[19] = mkv(0, 0, 1, 0, 1, 1, 3, 1,  1, 3);
    tbl[20] = mkv(0, 0, 1, 0, 1, 1, 0, 0,  2, 3);
    tbl[21] = mkv(0, 0, 1, 1, 1, 1, 1, 0,  3, 3);
    tbl[22] = mkv(0, 0, 1, 1, 1, 1, 2, 0, -1, 3);
    tbl[23] = mkv(0, 0, 1, 1, 1, 1, 3, 1, -1, 3);
    tbl[24] = mkv(0, 0, 1, 1, 1, 0, 0, 0, -1, 3);

    for (int c = 0; c < 25; c++) begin
      win_valid = tbl[c].wv;
      win_data  = mkwin(tbl[c].wsel);
      out_ready = tbl[c].ordy;
      @(negedge clk);
      chk($sformatf("tbl[%0d].wr", c), BW'(win_ready), BW'(tbl[c].e_wr));
      chk($sformatf("tbl[%0d].ena", c), BW'(ena), BW'(tbl[c].e_ena));
      chk($sformatf("tbl[%0d].ov", c), BW'(out_valid), BW'(tbl[c].e_ov));
      chk($sformatf("tbl[%0d].phase", c), BW'(out_phase), BW'(tbl[c].e_oph));
      chk($sformatf("tbl[%0d].last", c), BW'(out_last), BW'(tbl[c].e_last));
      chk($sformatf("tbl[%0d].pbus", c), p_bus, mkwin(tbl[c].e_psel));
      chk_w($sformatf("tbl[%0d]", c), tbl[c].e_k);
      adv();
    end

`ifdef BICUBIC_SCHED_PERF_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    chk("stall_cnt", BW'(stall_cnt), BW'(exp_stall));

    // back-to-back: three windows with win_valid held high
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      win_valid = (acc < 3);
      win_data  = mkwin(4 + acc);
      @(negedge clk);
      if (c <= 12) chk($sformatf("b2b[%0d].wr", c), BW'(win_ready), BW'(c % 4 == 0));
      chk($sformatf("b2b[%0d].ov", c), BW'(out_valid), BW'(c >= 3 && c <= 14));
      if (c >= 3 && c <= 14) begin
        chk($sformatf("b2b[%0d].phase", c), BW'(out_phase), BW'((c - 3) % 4));
        chk($sformatf("b2b[%0d].last", c), BW'(out_last), BW'((c - 3) % 4 == 3));
      end
      if (c >= 1 && c <= 12) chk($sformatf("b2b[%0d].pbus", c), p_bus, mkwin(4 + (c - 1) / 4));
      if (win_valid && win_ready) acc++;
      adv();
    end
    win_valid = 1'b0;
    chk("b2b.accepted", BW'(acc), BW'(3));

    // reset mid-ISSUE discards in-flight phases
    win_valid = 1'b1;
    win_data  = mkwin(7);
    adv();
    win_valid = 1'b0;
    adv();
    adv();
    rst = 1'b1;
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.ov", BW'(out_valid), BW'(1'b0));
    chk("mrst.wr", BW'(win_ready), BW'(1'b1));
    chk("mrst.pbus", p_bus, '0);
    chk("mrst.stall", BW'(stall_cnt), BW'(32'd0));
    chk_w("mrst", -1);
    adv();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mrst[%0d].ov", c), BW'(out_valid), BW'(1'b0));
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
